pattern_scan_ctrl: RTL and testbench

Sequencing controller that accepts parallel data words over a valid/ready handshake and serializes each word MSB-first, one bit per clock. It runs a programmable overlapping serial-pattern match on the bit stream and counts matches per word. It reports each match as a pulse and delivers the per-word count with a done strobe. It sits between a word-oriented producer and the team's serial sequence-detection path and owns that path's pattern configuration.

---
 rtl/pattern_scan_ctrl.sv | 123 ++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_scan_ctrl.sv
// Word-to-serial scan controller: shifts each accepted word out MSB-first, runs an
// overlapping pattern match on the bit stream and reports per-word match counts.
module pattern_scan_ctrl #(
   parameter int unsigned      DATA_W  = 16,
   parameter int unsigned      PAT_W   = 6,
   parameter int unsigned      CNT_W   = 5,
   parameter logic [PAT_W-1:0] PAT_RST = 6'b110101
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [PAT_W-1:0]  cfg_pattern,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              busy,
   output logic              hit,
   output logic              done,
   output logic [CNT_W-1:0]  match_count,
   output logic              sat
);

   localparam int unsigned BC_W = $clog2(DATA_W + 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
   localparam logic [1:0] ST_REPORT = 2'd2;

   localparam logic [BC_W-1:0]  BC_LAST = BC_W'(DATA_W);
   localparam logic [BC_W-1:0]  BC_PAT  = BC_W'(PAT_W);
   localparam logic [BC_W-1:0]  BC_ONE  = BC_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [1:0]        state_r;
   logic [DATA_W-1:0] shift_r;
   logic [PAT_W-1:0]  win_r;
   logic [PAT_W-1:0]  pat_r;
   logic [BC_W-1:0]   bit_cnt_r;
   logic [CNT_W-1:0]  cnt_r;
   logic              sat_r;
   logic              hit_r;

   logic [PAT_W-1:0]  win_next_s;
   logic [BC_W-1:0]   bit_cnt_next_s;
   logic              match_s;

   // Window after the current bit enters, and whether it completes a match in this word
   always_comb begin
      win_next_s     = {win_r[PAT_W-2:0], shift_r[DATA_W-1]};
      bit_cnt_next_s = bit_cnt_r + BC_ONE;
      match_s        = 1'b0;
      if ((state_r == ST_SHIFT) && (win_next_s == pat_r) && (bit_cnt_next_s >= BC_PAT)) begin
         match_s = 1'b1;
      end else begin
         match_s = 1'b0;
      end
   end

   // Sequencer: accept, shift one bit per clock, then hold one report cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= ST_IDLE;
         shift_r   <= '0;
         win_r     <= '0;
         pat_r     <= PAT_RST;
         bit_cnt_r <= '0;
         cnt_r     <= '0;
         sat_r     <= 1'b0;
         hit_r     <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               hit_r <= 1'b0;
               // A pattern written on the handshake edge applies to the word being accepted
               if (cfg_we) begin
                  pat_r <= cfg_pattern;
               end
               if (in_valid) begin
                  shift_r   <= in_data;
                  win_r     <= '0;
                  bit_cnt_r <= '0;
                  cnt_r     <= '0;
                  sat_r     <= 1'b0;
                  state_r   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               shift_r   <= {shift_r[DATA_W-2:0], 1'b0};
               win_r     <= win_next_s;
               bit_cnt_r <= bit_cnt_next_s;
               hit_r     <= match_s;
               if (match_s) begin
                  if (cnt_r == CNT_MAX) begin
                     sat_r <= 1'b1;
                  end else begin
                     cnt_r <= cnt_r + CNT_ONE;
                  end
               end
               if (bit_cnt_next_s == BC_LAST) begin
                  state_r <= ST_REPORT;
               end
            end
            ST_REPORT: begin
               hit_r   <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               hit_r   <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready    = (state_r == ST_IDLE);
   assign busy        = (state_r != ST_IDLE);
   assign done        = (state_r == ST_REPORT);
   assign hit         = hit_r;
   assign match_count = cnt_r;
   assign sat         = sat_r;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: a word-level model predicts every output each cycle
// for a default instance and a 2-bit-counter instance sharing the same stimulus.
module tb_pattern_scan_ctrl;

   localparam int DW = 16;
   localparam int PW = 6;
   localparam logic [5:0] PAT_DEF = 6'b110101;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_we;
   logic [5:0]  cfg_pattern;
   logic        in_valid;
   logic [15:0] in_data;

   logic        in_ready, busy, hit, done, sat;
   logic [4:0]  match_count;
   logic        in_ready2, busy2, hit2, done2, sat2;
   logic [1:0]  match_count2;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   pattern_scan_ctrl dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .busy(busy),
      .hit(hit), .done(done), .match_count(match_count), .sat(sat)
   );

   pattern_scan_ctrl #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2), .busy(busy2),
      .hit(hit2), .done(done2), .match_count(match_count2), .sat(sat2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Hit positions (bit index k = number of bits shifted) for a whole word
   function automatic logic [16:0] hits_of(input logic [15:0] word, input logic [5:0] pat);
      logic [16:0] r;
      logic [15:0] w;
      r = 17'h0;
      for (int k = PW; k <= DW; k++) begin
         w = (word >> (DW - k)) & 16'h003F;
         if (w == {10'h000, pat}) r[k] = 1'b1;
      end
      return r;
   endfunction

   // Model state
   logic        m_busy;
   int          m_k;
   logic [5:0]  m_pat;
   logic [16:0] m_hits;
   int          m_cnt, m_cnt2;
   logic        m_sat, m_sat2, m_hit;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_busy <= 1'b0; m_k <= 0; m_pat <= PAT_DEF; m_hits <= 17'h0;
         m_cnt <= 0; m_cnt2 <= 0; m_sat <= 1'b0; m_sat2 <= 1'b0; m_hit <= 1'b0;
      end else if (!m_busy) begin
         m_hit <= 1'b0;
         if (cfg_we) m_pat <= cfg_pattern;
         if (in_valid) begin
            m_busy <= 1'b1;
            m_k    <= 0;
            m_hits <= hits_of(in_data, cfg_we ? cfg_pattern : m_pat);
            m_cnt <= 0; m_cnt2 <= 0; m_sat <= 1'b0; m_sat2 <= 1'b0;
         end
      end else if (m_k < DW) begin
         m_k   <= m_k + 1;
         m_hit <= m_hits[m_k + 1];
         if (m_hits[m_k + 1]) begin
            if (m_cnt == 31) m_sat <= 1'b1; else m_cnt <= m_cnt + 1;
            if (m_cnt2 == 3) m_sat2 <= 1'b1; else m_cnt2 <= m_cnt2 + 1;
         end
      end else begin
         m_busy <= 1'b0;
         m_hit  <= 1'b0;
      end
   end

   // Observed per-word results, pinned later against hand-computed literals
   logic [16:0] obs_mask;
   logic [16:0] last_mask;
   int          last_cnt, last_cnt2;
   logic        last_sat, last_sat2;
   int          hs_times[$];

   always @(negedge clk) begin
      chk("in_ready", int'(in_ready), int'(!m_busy));
      chk("busy", int'(busy), int'(m_busy));
      chk("hit", int'(hit), int'(m_hit));
      chk("done", int'(done), int'(m_busy && m_k == DW));
      chk("match_count", int'(match_count), m_cnt);
      chk("sat", int'(sat), int'(m_sat));
      chk("in_ready2", int'(in_ready2), int'(!m_busy));
      chk("hit2", int'(hit2), int'(m_hit));
      chk("done2", int'(done2), int'(m_busy && m_k == DW));
      chk("match_count2", int'(match_count2), m_cnt2);
      chk("sat2", int'(sat2), int'(m_sat2));
      if (m_busy && m_k == 0) obs_mask = 17'h0;
      else if (m_busy && hit) obs_mask[m_k] = 1'b1;
      if (m_busy && m_k == DW) begin
         last_mask = obs_mask;
         last_cnt  = int'(match_count);
         last_sat  = sat;
         last_cnt2 = int'(match_count2);
         last_sat2 = sat2;
      end
      if (rst && in_ready && in_valid) hs_times.push_back(cyc + 1);
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [15:0] d, input logic we, input logic [5:0] p);
      in_valid = 1'b1; in_data = d; cfg_we = we; cfg_pattern = p;
      step();
      in_valid = 1'b0; cfg_we = 1'b0;
   endtask

   // Waits for done (bounded), then one more edge so the controller is idle again
   task automatic wait_done(output int n);
      bit seen;
      seen = 1'b0;
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            n = i;
            break;
         end
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL done_timeout actual=none expected=done within 40 cycles");
      end
      step();
   endtask

   task automatic chk_word(input string tag, input int mask, input int cnt, input int s,
                           input int cnt2, input int s2);
      chk({tag, "_mask"}, int'(last_mask), mask);
      chk({tag, "_count"}, last_cnt, cnt);
      chk({tag, "_sat"}, int'(last_sat), s);
      chk({tag, "_count2"}, last_cnt2, cnt2);
      chk({tag, "_sat2"}, int'(last_sat2), s2);
   endtask

   int n;

   initial begin
      rst = 1'b0; cfg_we = 1'b0; cfg_pattern = 6'h00; in_valid = 1'b0; in_data = 16'h0000;
      step();
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_count", int'(match_count), 0);
      step();
      rst = 1'b1;

      // Default pattern on D5D5: hits after E6 and E14, done 17 cycles after handshake
      send(16'hD5D5, 1'b0, 6'h00);
      wait_done(n);
      chk("d5d5_done_latency", n, 17);
      chk_word("d5d5", 32'h4040, 2, 0, 2, 0);

      // Overlapping matches, pattern written on the handshake edge; 2-bit counter saturates
      send(16'hAAAA, 1'b1, 6'b101010);
      wait_done(n);
      chk_word("aaaa", 32'h15540, 6, 0, 3, 1);

      cfg_we = 1'b1; cfg_pattern = PAT_DEF;
      step();
      cfg_we = 1'b0;
      send(16'h0000, 1'b0, 6'h00);
      wait_done(n);
      chk_word("zero", 0, 0, 0, 0, 0);

      // Pattern write during the scan is dropped
      send(16'hD5D5, 1'b0, 6'h00);
      step(); step();
      cfg_we = 1'b1; cfg_pattern = 6'b000000;
      step();
      cfg_we = 1'b0;
      wait_done(n);
      chk_word("midwr", 32'h4040, 2, 0, 2, 0);

      send(16'hFC0F, 1'b1, 6'b000000);
      wait_done(n);
      chk_word("fc0f", 32'h1000, 1, 0, 1, 0);

      // Sustained valid: one handshake every 18 cycles
      hs_times.delete();
      in_valid = 1'b1; in_data = 16'hD5D5;
      repeat (40) step();
      in_valid = 1'b0;
      wait_done(n);
      chk("hs_count", hs_times.size(), 3);
      if (hs_times.size() >= 3) begin
         chk("hs_gap1", hs_times[1] - hs_times[0], 18);
         chk("hs_gap2", hs_times[2] - hs_times[1], 18);
      end

      // Reset mid-scan restores outputs and the default pattern
      cfg_we = 1'b1; cfg_pattern = 6'b101010;
      step();
      cfg_we = 1'b0;
      send(16'hD5D5, 1'b0, 6'h00);
      repeat (9) step();
      rst = 1'b0;
      #1;
      chk("mid_rst_in_ready", int'(in_ready), 1);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_hit", int'(hit), 0);
      chk("mid_rst_done", int'(done), 0);
      chk("mid_rst_count", int'(match_count), 0);
      chk("mid_rst_sat", int'(sat2), 0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      send(16'hD5D5, 1'b0, 6'h00);
      wait_done(n);
      chk("post_rst_latency", n, 17);
      chk_word("post_rst", 32'h4040, 2, 0, 2, 0);

      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
